// File: rtl/simd_sum_pkg.sv
// Shared widths, word layout and stage bundles for the SIMD sum collector.
// Used by the collector top and its output FIFO.
package simd_sum_pkg;

    localparam int LANE_W    = 11;
    localparam int N_LANES   = 4;
    localparam int PAIR_W    = 12;
    localparam int SUM_W     = 13;
    localparam int WORD_W    = 57;
    localparam int TOTAL_LSB = 44;

    typedef logic [LANE_W-1:0] lane_t;

    typedef struct packed {
        logic                      vld;
        logic [PAIR_W-1:0]         p0;
        logic [PAIR_W-1:0]         p1;
        lane_t [N_LANES-1:0]       z;
    } s1_t;

    typedef struct packed {
        logic                      vld;
        logic [SUM_W-1:0]          total;
        lane_t [N_LANES-1:0]       z;
    } s2_t;

    // Lane 0 (z1) lands in the low bits, total in [WORD_W-1:TOTAL_LSB].
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [SUM_W-1:0]    total,
        input lane_t [N_LANES-1:0] z
    );
        return {total, z};
    endfunction

endpackage

// File: rtl/simd_sum_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy counter.
// Ports: clk/rst, wr/din push, rd pop, dout head word, full/empty/count.
module simd_sum_fifo #(
    parameter int WIDTH = 57,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign rd_ok = rd & ~empty;
    // When full, a same-cycle pop frees the head slot, which is exactly
    // where the write pointer sits, so the write may proceed.
    assign wr_ok = wr & (~full | rd_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/simd_sum_collector.sv
// Collects 4 SIMD lane sums, reduces them to a total in two stages and
// buffers packed words; ap_fifo read port plus backpressure/drop status.
module simd_sum_collector
    import simd_sum_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2,
    localparam int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_ce,
    input  logic [LANE_W-1:0] z1,
    input  logic [LANE_W-1:0] z2,
    input  logic [LANE_W-1:0] z3,
    input  logic [LANE_W-1:0] z4,
    input  logic              z_vld,
    output logic [WORD_W-1:0] dout,
    output logic              empty_n,
    input  logic              read,
    output logic              almost_full,
    output logic              overflow,
    output logic [15:0]       drop_cnt,
    output logic [CNT_W-1:0]  occupancy
);

    s1_t         s1_q, s1_d;
    s2_t         s2_q, s2_d;
    logic        overflow_q, overflow_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        wr;
    logic        rd;
    logic        full;
    logic        empty;
    logic        drop;

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (ap_ce) begin
            s1_d.vld   = z_vld;
            s1_d.p0    = PAIR_W'(z1) + PAIR_W'(z2);
            s1_d.p1    = PAIR_W'(z3) + PAIR_W'(z4);
            s1_d.z     = {z4, z3, z2, z1};
            s2_d.vld   = s1_q.vld;
            s2_d.total = SUM_W'(s1_q.p0) + SUM_W'(s1_q.p1);
            s2_d.z     = s1_q.z;
        end
    end

    // S2 only changes under ap_ce, so gating the write with ap_ce
    // writes each S2 word exactly once.
    assign wr   = s2_q.vld & ap_ce;
    assign rd   = read & empty_n;
    assign drop = wr & full & ~rd;

    always_comb begin
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    simd_sum_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (ap_clk),
        .rst   (ap_rst),
        .wr    (wr),
        .din   (pack_word(s2_q.total, s2_q.z)),
        .rd    (rd),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    assign empty_n     = ~empty;
    assign almost_full = (occupancy >= CNT_W'(DEPTH - AFULL_MARGIN));
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: doc/simd_sum_collector.md
Name: simd_sum_collector

Overview:
- Downstream stage of the 4-lane SIMD adder. Consumes its four 11-bit lane sums z1..z4 together with the shared valid.
- Reduces the four lanes to one 13-bit total and packs total plus lanes into one 57-bit word.
- Buffers words in a small synchronous FIFO exposed as an ap_fifo-style read port (dout/empty_n/read).
- Reports backpressure (almost_full) and overflow/drop statistics.

Parameters:
- DEPTH, 8, FIFO depth in words; power of two, >= 4.
- AFULL_MARGIN, 2, almost_full asserts when occupancy >= DEPTH-AFULL_MARGIN.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- ap_ce  in  1  clock enable for the input pipeline and FIFO write side.
- z1, z2, z3, z4  in  11 each  unsigned lane sums from the SIMD adder.
- z_vld  in  1  lanes valid this cycle (adder's shared z*_ap_vld).
- dout  out  57  {total[12:0], z4, z3, z2, z1}; total in [56:44], z1 in [10:0].
- empty_n  out  1  FIFO holds at least one word; dout is valid.
- read  in  1  pop head word; ignored when empty_n=0.
- almost_full  out  1  occupancy >= DEPTH-AFULL_MARGIN; upstream uses it to drop ap_ce/ap_start.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- drop_cnt  out  16  number of dropped words, saturates at 16'hFFFF.
- occupancy  out  $clog2(DEPTH)+1  current FIFO word count.

Behaviour:
- Reset (ap_rst=1 at an edge):
  - Clears all pipeline valids, FIFO pointers, occupancy, overflow and drop_cnt.
  - After reset: empty_n=0, almost_full=0, dout=0.
  - A reset mid-stream discards in-flight and buffered words; no partial word may appear afterwards.
- Arithmetic: unsigned, no truncation. S1 computes p0=z1+z2 and p1=z3+z4 (12-bit each). S2 computes total=p0+p1 (13-bit); max 4*2047=8188 fits.
- Pipeline: 2 register stages, S1 (pair sums, lanes, v1) and S2 (total, lanes, v2). Both advance only when ap_ce=1; with ap_ce=0 all stage registers hold.
- Latency: z_vld=1 sampled at edge E0 -> S1 at E0, S2 at E1, FIFO write at E2 -> empty_n=1 and dout valid in the cycle after E2 (3 edges, with ap_ce continuously 1).
- Write condition: wr = v2 & ap_ce. Each S2 word is written exactly once, because S2 only changes under ap_ce.
- Read condition: rd = read & empty_n. The read side ignores ap_ce. dout shows the head word combinationally from the storage at the read pointer (first-word-fall-through); it updates the cycle after a pop.
- Full handling:
  - wr while occupancy==DEPTH and no rd -> word dropped, overflow<=1, drop_cnt increments (saturating), occupancy unchanged.
  - wr and rd in the same cycle while full -> both succeed, occupancy stays DEPTH, no drop.
- Empty handling: rd is impossible when empty (gated by empty_n). wr into an empty FIFO makes empty_n=1 next cycle; there is no same-cycle bypass.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. Occupancy is a separate counter: +1 on wr-only, -1 on rd-only, unchanged on both or neither.
- almost_full, empty_n and overflow are registered-derived, i.e. decoded from registered state with no combinational path from inputs.
- overflow clears only on ap_rst.

Decomposition:
- Package simd_sum_pkg holds LANE_W=11, N_LANES=4, PAIR_W=12, SUM_W=13, WORD_W=57, and the word field offsets (TOTAL_LSB=44).
- One sub-module, simd_sum_fifo: parameterised sync FIFO (WIDTH, DEPTH) with wr/rd/full/empty/occupancy.
- Pipeline, pack, and overflow/drop logic stay in the top module.

Test Plan:
- Reset then single word: z1..z4=1,2,3,4, z_vld=1 for 1 cycle, ap_ce=1 -> empty_n rises 3 edges later; dout[56:44]=10, dout[43:0]={4,3,2,1}. read=1 -> empty_n=0 next cycle.
- Max values: all lanes 2047 -> total=8188 (13'h1FFC); no wrap.
- ap_ce stall: valid word, then ap_ce=0 for 5 cycles after E0 -> no write during the stall; exactly one word is written 2 ce-cycles after ap_ce returns.
- Fill/overflow: read=0, 10 consecutive valid words (DEPTH=8):
  - occupancy reaches 8; almost_full=1 from occupancy 6.
  - overflow=1 and drop_cnt=2.
  - Draining returns words 1..8 in order.
- Simultaneous rd/wr at full: full FIFO, read=1 with continuous z_vld -> occupancy stays 8, drop_cnt unchanged, output order preserved across pointer wrap (>= 3*DEPTH words).
- Reset mid-operation: 5 buffered words plus 2 in flight, assert ap_rst for 1 cycle -> empty_n=0, occupancy=0, overflow=0, drop_cnt=0; no stale word emerges in the following 4 cycles.
